// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module   : fetch_sequencer_pkg
// Brief    : Shared constants and FSM state encoding for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

  localparam int          DEFAULT_WORD_SIZE  = 32;
  localparam logic [31:0] DEFAULT_PC_INITIAL = 32'h0000_0000;
  localparam int          INSTR_BYTES        = 4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fs_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Handshaked instruction-memory port (single outstanding request).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
  parameter int WORD_SIZE = 32
) ();

  logic                 imem_req;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic                 imem_rvalid;
  logic [WORD_SIZE-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer_skid_buffer.sv
// ============================================================================
// Module   : fetch_skid_buffer
// Brief    : One-entry {instr, pc, pcplus4} holding register with full flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 unload,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] d_instr,
  input  logic [WORD_SIZE-1:0] d_pc,
  input  logic [WORD_SIZE-1:0] d_pcplus4,
  output logic [WORD_SIZE-1:0] q_instr,
  output logic [WORD_SIZE-1:0] q_pc,
  output logic [WORD_SIZE-1:0] q_pcplus4,
  output logic                 full
);

  logic                 r_full;
  logic [WORD_SIZE-1:0] r_instr;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_pcplus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full    <= 1'b0;
      r_instr   <= '0;
      r_pc      <= '0;
      r_pcplus4 <= '0;
    end else begin
      if (clear || unload) begin
        r_full <= 1'b0;
      end else if (load) begin
        r_full <= 1'b1;
      end
      if (load && !clear) begin
        r_instr   <= d_instr;
        r_pc      <= d_pc;
        r_pcplus4 <= d_pcplus4;
      end
    end
  end

  assign q_instr   = r_instr;
  assign q_pc      = r_pc;
  assign q_pcplus4 = r_pcplus4;
  assign full      = r_full;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and imem request sequencer feeding the F/D register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                   WORD_SIZE  = DEFAULT_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] PC_INITIAL = WORD_SIZE'(DEFAULT_PC_INITIAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallD,
  input  logic                 PCSrcE,
  input  logic [WORD_SIZE-1:0] PCTargetE,
  fetch_sequencer_if.master    imem,
  output logic [WORD_SIZE-1:0] InstrD,
  output logic [WORD_SIZE-1:0] PCD,
  output logic [WORD_SIZE-1:0] PCPlus4D,
  output logic                 ValidD
);

  localparam logic [WORD_SIZE-1:0] c_STEP = WORD_SIZE'(INSTR_BYTES);

  fs_state_e            r_state;
  fs_state_e            w_state_next;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_inflight_pc;
  logic                 r_drop;
  logic [WORD_SIZE-1:0] r_instr_d;
  logic [WORD_SIZE-1:0] r_pc_d;
  logic [WORD_SIZE-1:0] r_pcplus4_d;
  logic                 r_valid_d;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_resp;
  logic                 w_deliver;
  logic                 w_skid_load;
  logic                 w_skid_unload;
  logic                 w_skid_full;
  logic [WORD_SIZE-1:0] w_skid_instr;
  logic [WORD_SIZE-1:0] w_skid_pc;
  logic [WORD_SIZE-1:0] w_skid_pcplus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request only depends on state and skid occupancy; no path from ack/rvalid.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_accept     = 1'b0;
    w_resp       = 1'b0;
    case (r_state)
      FS_IDLE: w_state_next = FS_REQ;
      FS_REQ: begin
        w_req = !w_skid_full;
        if (!w_skid_full && imem.imem_ack) begin
          w_accept     = 1'b1;
          w_state_next = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem.imem_rvalid) begin
          w_resp       = 1'b1;
          w_state_next = FS_REQ;
        end
      end
      default: w_state_next = FS_IDLE;
    endcase
  end

  assign w_deliver     = w_resp && !r_drop && !PCSrcE;
  assign w_skid_load   = w_deliver && r_valid_d && StallD;
  assign w_skid_unload = !PCSrcE && !w_deliver && r_valid_d && !StallD && w_skid_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= PC_INITIAL;
      r_inflight_pc <= '0;
      r_drop        <= 1'b0;
      r_instr_d     <= '0;
      r_pc_d        <= '0;
      r_pcplus4_d   <= '0;
      r_valid_d     <= 1'b0;
    end else begin
      if (PCSrcE) begin
        r_pc <= PCTargetE;
      end else if (w_accept) begin
        r_pc <= r_pc + c_STEP;
      end

      if (w_accept) begin
        r_inflight_pc <= r_pc;
      end

      // A redirect orphans any accepted-but-unanswered request.
      if (PCSrcE && (w_accept || (r_state == FS_WAIT && !imem.imem_rvalid))) begin
        r_drop <= 1'b1;
      end else if (w_resp) begin
        r_drop <= 1'b0;
      end

      if (PCSrcE) begin
        r_valid_d <= 1'b0;
      end else if (w_deliver && (!r_valid_d || !StallD)) begin
        r_instr_d   <= imem.imem_rdata;
        r_pc_d      <= r_inflight_pc;
        r_pcplus4_d <= r_inflight_pc + c_STEP;
        r_valid_d   <= 1'b1;
      end else if (w_skid_unload) begin
        r_instr_d   <= w_skid_instr;
        r_pc_d      <= w_skid_pc;
        r_pcplus4_d <= w_skid_pcplus4;
        r_valid_d   <= 1'b1;
      end else if (r_valid_d && !StallD) begin
        r_valid_d <= 1'b0;
      end
    end
  end

  fetch_skid_buffer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (w_skid_load),
    .unload    (w_skid_unload),
    .clear     (PCSrcE),
    .d_instr   (imem.imem_rdata),
    .d_pc      (r_inflight_pc),
    .d_pcplus4 (r_inflight_pc + c_STEP),
    .q_instr   (w_skid_instr),
    .q_pc      (w_skid_pc),
    .q_pcplus4 (w_skid_pcplus4),
    .full      (w_skid_full)
  );

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign InstrD         = r_instr_d;
  assign PCD            = r_pc_d;
  assign PCPlus4D       = r_pcplus4_d;
  assign ValidD         = r_valid_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed bench with a queue-level reference model of fetch delivery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         StallD;
  logic         PCSrcE;
  logic [W-1:0] PCTargetE;
  logic [W-1:0] InstrD;
  logic [W-1:0] PCD;
  logic [W-1:0] PCPlus4D;
  logic         ValidD;

  fetch_sequencer_if #(.WORD_SIZE(W)) imem_bus ();

  fetch_sequencer #(
    .WORD_SIZE  (W),
    .PC_INITIAL (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem_bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  // Model view: a request is outstanding or not; Decode sees a FIFO of up to
  // two live instructions (front = presented), and keeps the last one shown.
  typedef struct packed {
    logic         alive;
    logic         outst;
    logic         drop;
    logic [1:0]   cnt;
    logic [W-1:0] pc;
    logic [W-1:0] inflight;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [W-1:0] hold_pc;
    logic [W-1:0] hold_pc4;
    logic [W-1:0] hold_instr;
  } model_t;

  model_t m;
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic logic [W-1:0] word(input logic [W-1:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic model_req(input model_t s);
    return s.alive && !s.outst && (s.cnt < 2'd2);
  endfunction

  function automatic model_t model_next(input model_t s, input logic ack, input logic rv,
                                        input logic stall, input logic br,
                                        input logic [W-1:0] tgt);
    model_t n;
    logic   req;
    logic   resp;
    n     = s;
    req   = model_req(s);
    resp  = s.outst && rv;
    n.alive = 1'b1;
    if (br) begin
      n.pc  = tgt;
      n.cnt = 2'd0;
      if (req && ack) begin
        n.outst = 1'b1;
        n.drop  = 1'b1;
      end else if (resp) begin
        n.outst = 1'b0;
        n.drop  = 1'b0;
      end else if (s.outst) begin
        n.drop = 1'b1;
      end
    end else begin
      if (req && ack) begin
        n.inflight = s.pc;
        n.pc       = s.pc + 32'd4;
        n.outst    = 1'b1;
      end
      if (s.cnt != 2'd0 && !stall) begin
        n.e0  = s.e1;
        n.cnt = s.cnt - 2'd1;
      end
      if (resp) begin
        n.outst = 1'b0;
        if (s.drop) begin
          n.drop = 1'b0;
        end else begin
          if (n.cnt == 2'd0) n.e0 = s.inflight;
          else               n.e1 = s.inflight;
          n.cnt = n.cnt + 2'd1;
        end
      end
      if (n.cnt != 2'd0) begin
        n.hold_pc    = n.e0;
        n.hold_pc4   = n.e0 + 32'd4;
        n.hold_instr = word(n.e0);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= model_next(m, imem_bus.imem_ack, imem_bus.imem_rvalid, StallD, PCSrcE, PCTargetE);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("ValidD",   32'(ValidD), 32'(m.cnt != 2'd0));
    chk("InstrD",   InstrD,   m.hold_instr);
    chk("PCD",      PCD,      m.hold_pc);
    chk("PCPlus4D", PCPlus4D, m.hold_pc4);
    chk("imem_req", 32'(imem_bus.imem_req), 32'(model_req(m)));
    if (model_req(m)) chk("imem_addr", imem_bus.imem_addr, m.pc);
  endtask

  task automatic step(input logic ack, input logic rv, input logic stall, input logic br,
                      input logic [W-1:0] tgt);
    imem_bus.imem_ack    = ack;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = m.drop ? 32'hDEAD_BEEF : word(m.inflight);
    StallD    = stall;
    PCSrcE    = br;
    PCTargetE = tgt;
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  initial begin
    rst = 1'b0;
    StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_req",   32'(imem_bus.imem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("idle_req", 32'(imem_bus.imem_req), 32'd0);

    // Back-to-back fetch from PC_INITIAL
    step(0, 0, 0, 0, '0);
    chk("first_addr", imem_bus.imem_addr, 32'h0);
    step(1, 0, 0, 0, '0);
    chk("wait_req", 32'(imem_bus.imem_req), 32'd0);
    step(0, 1, 0, 0, '0);
    chk("d0_valid", 32'(ValidD), 32'd1);
    chk("d0_pc",    PCD, 32'h0);
    chk("d0_pc4",   PCPlus4D, 32'h4);
    chk("d0_instr", InstrD, 32'hA5A5_FFFF);
    chk("addr4",    imem_bus.imem_addr, 32'h4);
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("addr8",    imem_bus.imem_addr, 32'h8);

    // Ack withheld: request and address hold
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, '0);
      chk("hold_addr", imem_bus.imem_addr, 32'h8);
      chk("hold_req",  32'(imem_bus.imem_req), 32'd1);
    end
    step(1, 0, 0, 0, '0);

    // Stall with a second instruction arriving -> skid
    step(0, 1, 0, 0, '0);
    step(1, 0, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    chk("skid_req", 32'(imem_bus.imem_req), 32'd0);
    chk("frz_pc",   PCD, 32'h8);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("skid_pc",  PCD, 32'hC);
    chk("skid_val", 32'(ValidD), 32'd1);

    // Redirect while waiting
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 1, 32'h100);
    chk("rd_valid", 32'(ValidD), 32'd0);
    step(0, 1, 0, 0, '0);
    chk("drop_valid", 32'(ValidD), 32'd0);
    chk("rd_addr",    imem_bus.imem_addr, 32'h100);
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("rd_pcd",  PCD, 32'h100);
    chk("rd_pc4",  PCPlus4D, 32'h104);

    // Redirect coincident with ack
    step(1, 0, 0, 1, 32'h200);
    step(0, 1, 0, 0, '0);
    chk("ra_valid", 32'(ValidD), 32'd0);
    chk("ra_addr",  imem_bus.imem_addr, 32'h200);

    // Redirect with stall and full skid
    step(1, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    step(1, 0, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    chk("full_req", 32'(imem_bus.imem_req), 32'd0);
    step(0, 0, 1, 1, 32'h300);
    chk("rs_valid", 32'(ValidD), 32'd0);
    chk("rs_req",   32'(imem_bus.imem_req), 32'd1);
    chk("rs_addr",  imem_bus.imem_addr, 32'h300);
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("rs_pcd",   PCD, 32'h300);

    // Retarget a pending request, then address wrap
    step(0, 0, 0, 1, 32'h400);
    chk("rt_addr",  imem_bus.imem_addr, 32'h400);
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("wr_pcd",  PCD, 32'hFFFF_FFFC);
    chk("wr_pc4",  PCPlus4D, 32'h0);
    chk("wr_addr", imem_bus.imem_addr, 32'h0);

    // Asynchronous reset during WAIT
    step(1, 0, 0, 0, '0);
    imem_bus.imem_ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(ValidD), 32'd0);
    chk("ar_instr", InstrD, 32'h0);
    chk("ar_pcd",   PCD, 32'h0);
    chk("ar_pc4",   PCPlus4D, 32'h0);
    chk("ar_req",   32'(imem_bus.imem_req), 32'd0);
    check_cycle();
    @(posedge clk);
    #1 rst = 1'b1;
    step(0, 1, 0, 0, '0);
    chk("late_valid", 32'(ValidD), 32'd0);
    chk("post_addr",  imem_bus.imem_addr, 32'h0);
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("post_pcd",   PCD, 32'h0);
    chk("post_valid", 32'(ValidD), 32'd1);
    step(0, 0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
